// File: rtl/uart_frame_parser_pkg.sv
// Shared constants for the UART frame parser: FSM encodings, error codes and helpers.
`default_nettype none

package uart_frame_parser_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_parser_buf.sv
// Payload store: register array with a synchronous write port and a combinational read port.
`default_nettype none

module uart_frame_parser_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte strobe and replays verified
// payloads as a valid/ready byte stream.
`default_nettype none

module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         CLK_FREQ     = 125_000_000,
  parameter int         BAUD_RATE    = 115_200,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * 20
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic [7:0]                   iRxByte,
  input  logic                         iRxDone,
  output logic [7:0]                   oData,
  output logic                         oValid,
  input  logic                         iReady,
  output logic                         oLast,
  output logic [$clog2(MAX_LEN+1)-1:0] oLen,
  output logic                         oFrameOk,
  output logic                         oFrameErr,
  output logic [1:0]                   oErrCode,
  output logic [7:0]                   oDropCnt
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  logic [2:0]       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic [7:0]       sum;
  logic [7:0]       chk_sum;
  logic [TMO_W-1:0] gap_cnt;
  logic             frame_ok;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [7:0]       drop_cnt;
  logic [7:0]       rd_data;
  logic             timed_state;
  logic             timeout;
  logic             len_bad;
  logic             buf_wr;

  assign len_m1      = len - LEN_W'(1);
  assign chk_sum     = sum + iRxByte;
  assign len_bad     = (iRxByte == 8'd0) || (iRxByte > MAX_LEN_B);
  assign timed_state = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // A strobe landing on the terminal count takes priority over the timeout.
  assign timeout     = timed_state && !iRxDone && (gap_cnt == TMO_LAST);
  assign buf_wr      = (state == S_PAYLOAD) && iRxDone;

  uart_frame_parser_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (iClk),
    .wr_en   (buf_wr),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (iRxByte),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sum       <= 8'd0;
      gap_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      drop_cnt  <= 8'd0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (iRxDone || !timed_state) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (timeout) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (iRxDone && (iRxByte == SOF_BYTE)) begin
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (iRxDone) begin
              if (len_bad) begin
                frame_err <= 1'b1;
                err_code  <= ERR_LEN;
                state     <= S_IDLE;
              end else begin
                len    <= iRxByte[LEN_W-1:0];
                sum    <= iRxByte;
                wr_ptr <= '0;
                state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (iRxDone) begin
              sum    <= chk_sum;
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == len_m1) begin
                state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (iRxDone) begin
              if (chk_sum == 8'd0) begin
                frame_ok <= 1'b1;
                rd_ptr   <= '0;
                state    <= S_OUT;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
                state     <= S_IDLE;
              end
            end
          end
          S_OUT: begin
            // The receiver cannot be stalled, so bytes arriving mid-stream are lost.
            if (iRxDone) begin
              drop_cnt <= sat_inc8(drop_cnt);
            end
            if (iReady) begin
              rd_ptr <= rd_ptr + 1'b1;
              if (rd_ptr == len_m1) begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign oValid    = (state == S_OUT);
  assign oData     = oValid ? rd_data : 8'h00;
  assign oLast     = oValid && (rd_ptr == len_m1);
  assign oLen      = oValid ? len : '0;
  assign oFrameOk  = frame_ok;
  assign oFrameErr = frame_err;
  assign oErrCode  = err_code;
  assign oDropCnt  = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with hand-computed frames and checksums.
`default_nettype none

module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;
  logic [4:0] len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  uart_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SOF_BYTE     (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iRxByte   (rx_byte),
    .iRxDone   (rx_done),
    .oData     (data),
    .oValid    (valid),
    .iReady    (ready),
    .oLast     (last),
    .oLen      (len),
    .oFrameOk  (frame_ok),
    .oFrameErr (frame_err),
    .oErrCode  (err_code),
    .oDropCnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         ok_cnt, err_cnt, both_cnt, valid_cycles;
  logic [7:0] rxq[$];
  logic       lastq[$];
  int         xcyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
    if (valid) valid_cycles++;
    if (valid && ready) begin
      rxq.push_back(data);
      lastq.push_back(last);
      xcyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    ok_cnt = 0;
    err_cnt = 0;
    both_cnt = 0;
    valid_cycles = 0;
    rxq.delete();
    lastq.delete();
    xcyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Bytes are packed most-significant first.
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(v[(n-1-i)*8 +: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input string tag, input logic [31:0] exp_bytes, input int n);
    logic [7:0] b;
    logic       l;
    check({tag, "_count"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rxq.size()) begin
        b = rxq[i];
        l = lastq[i];
        check({tag, "_data"}, b, exp_bytes[(n-1-i)*8 +: 8]);
        check({tag, "_last"}, l, (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_len"}, len, 0);
    check({tag, "_ok"}, frame_ok, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    int k;
    rst_n   = 1'b0;
    rx_byte = 8'h00;
    rx_done = 1'b0;
    ready   = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Good frame: LEN+payload = 03+11+22+33 = 0x69, so CHK = 0x97.
    clear_mon();
    send_bytes(64'hA5_03_11_22_33_97, 6);
    check("good_ok_pulse", frame_ok, 1);
    check("good_first_valid", valid, 1);
    check("good_first_data", data, 8'h11);
    check("good_len", len, 3);
    idle(6);
    check("good_ok_cnt", ok_cnt, 1);
    check("good_err_cnt", err_cnt, 0);
    expect_stream("good", 32'h00112233, 3);
    if (xcyc.size() == 3) check("good_back_to_back", xcyc[2] - xcyc[0], 2);
    check("good_valid_drop", valid, 0);

    // Bad checksum: 02+10+20+00 = 0x32, not zero.
    clear_mon();
    send_bytes(64'hA5_02_10_20_00, 5);
    check("badchk_err_pulse", frame_err, 1);
    check("badchk_code", err_code, 2);
    idle(6);
    check("badchk_err_cnt", err_cnt, 1);
    check("badchk_no_valid", valid_cycles, 0);
    // 01+42 = 0x43, CHK = 0xBD.
    send_bytes(64'hA5_01_42_BD, 4);
    idle(4);
    check("badchk_next_ok", ok_cnt, 1);
    check("badchk_code_held", err_code, 2);
    expect_stream("badchk_next", 32'h00000042, 1);

    // Bad length: zero, then MAX_LEN+1.
    clear_mon();
    send_bytes(64'hA5_00, 2);
    check("len0_err_pulse", frame_err, 1);
    check("len0_code", err_code, 1);
    send_bytes(64'hA5_01_42_BD, 4);
    idle(4);
    check("len0_next_ok", ok_cnt, 1);
    clear_mon();
    send_bytes(64'hA5_11, 2);
    check("len17_err_pulse", frame_err, 1);
    check("len17_code", err_code, 1);
    // Would parse as a good frame if LEN were still expected.
    send_bytes(64'h03_11_22_33_97, 5);
    idle(4);
    check("len17_ignored_ok", ok_cnt, 0);
    check("len17_err_cnt", err_cnt, 1);

    // Timeout after the first payload byte.
    clear_mon();
    send_bytes(64'hA5_02_11, 3);
    k = 0;
    for (int i = 1; i <= TMO + 10; i++) begin
      @(posedge clk); #1;
      if (frame_err && k == 0) k = i;
    end
    check("tmo_latency", k, TMO);
    check("tmo_code", err_code, 3);
    check("tmo_err_cnt", err_cnt, 1);
    send_bytes(64'hA5_01_42_BD, 4);
    idle(4);
    check("tmo_next_ok", ok_cnt, 1);

    // Strobe exactly on the terminal count keeps the frame: 02+11+22 = 0x35, CHK = 0xCB.
    clear_mon();
    send_bytes(64'hA5_02, 2);
    repeat (TMO - 2) @(posedge clk);
    send_bytes(64'h11_22_CB, 3);
    idle(4);
    check("tmo_edge_err_cnt", err_cnt, 0);
    check("tmo_edge_ok_cnt", ok_cnt, 1);
    expect_stream("tmo_edge", 32'h00001122, 2);

    // Backpressure and overrun: 04+01+02+03+04 = 0x0E, CHK = 0xF2.
    clear_mon();
    ready = 1'b0;
    send_bytes(64'hA5_04_01_02_03_04_F2, 7);
    check("bp_valid", valid, 1);
    check("bp_data0", data, 8'h01);
    send_bytes(64'hA5_A5_00, 3);
    check("bp_drop_cnt", drop_cnt, 3);
    check("bp_data_held", data, 8'h01);
    check("bp_last_held", last, 0);
    check("bp_len_held", len, 4);
    ready = 1'b1;
    idle(8);
    expect_stream("bp", 32'h01020304, 4);
    check("bp_ok_cnt", ok_cnt, 1);
    check("bp_drop_final", drop_cnt, 3);

    // Noise before SOF, then reset in the middle of a payload.
    clear_mon();
    send_bytes(64'h00_FF_5A_A5_03_11, 6);
    check("noise_no_pulse", ok_cnt + err_cnt, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    send_bytes(64'hA5_03_11_22_33_97, 6);
    idle(6);
    check("fresh_ok_cnt", ok_cnt, 1);
    check("fresh_err_cnt", err_cnt, 0);
    expect_stream("fresh", 32'h00112233, 3);

    check("never_both_pulses", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
